// File: rtl/root_tx_arbiter.sv
// Packet-level round-robin arbiter for the Root Node's single router injection port.
// A granted requester keeps the port until its last flit is accepted; flits leave through a one-entry register.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif

module root_tx_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = `ROUTER_WIDTH,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic                          router_rdy,
  output logic                          tx_en,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        rr_ptr, rr_nxt;
  logic [IDX_W-1:0]        grant_nxt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_found;
  logic                    out_adv;
  logic                    xfer;
  logic                    xfer_last;
  logic [DATA_WIDTH-1:0]   grant_data;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  // The output register can take a new flit when it is empty or being drained this cycle.
  assign out_adv    = ~tx_en | router_rdy;
  assign grant_data = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign xfer       = (state == LOCKED) & req_valid[grant_idx] & out_adv;
  assign xfer_last  = xfer & req_last[grant_idx];
  assign busy       = (state == LOCKED) | tx_en;

  // Scan downwards so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(int'(rr_ptr) + k);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    rr_nxt    = rr_ptr;
    req_rdy   = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        req_rdy[grant_idx] = out_adv;
        if (xfer_last) begin
          state_nxt = IDLE;
          rr_nxt    = wrap_idx(int'(grant_idx) + 1);
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      grant_idx <= grant_nxt;
    end
  end

  // A held flit stays put under backpressure; an advancing register with no transfer emits a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else if (out_adv) begin
      tx_en <= xfer;
      if (xfer) begin
        tx_data <= grant_data;
      end
    end
  end

endmodule

// File: tb/tb_root_tx_arbiter.sv
// Scoreboard bench for root_tx_arbiter: per-requester packet queues drive the inputs,
// a monitor checks every accepted output flit, packet contiguity, grant order and hold-under-stall.
module tb_root_tx_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DW      = 32;
  localparam int IDX_W   = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          first;
    int            gap;
  } flit_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_rdy;
  logic                  router_rdy;
  logic                  tx_en;
  logic [DW-1:0]         tx_data;
  logic [IDX_W-1:0]      grant_idx;
  logic                  busy;

  root_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DW),
    .IDX_W     (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .router_rdy(router_rdy),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  flit_t flit_q[NUM_REQ][$];   // what each requester still has to send
  flit_t exp_q[NUM_REQ][$];    // what must still appear at the output, per requester
  int    exp_grant[$];         // expected winner order for directed tests
  int    checks      = 0;
  int    failures    = 0;
  int    pkts_started = 0;
  int    pkt_seq     = 0;
  int    wait_start[NUM_REQ];
  bit    wait_active[NUM_REQ];
  bit    mon_on      = 1'b0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flit payload: {src, packet sequence, flit index, random byte}.
  task automatic push_pkt(input int src, input int len, input int first_gap, input int mid_pct,
                          input bit to_exp, input int gap_flit, input int gap_len);
    flit_t fl;
    for (int f = 0; f < len; f++) begin
      fl.data  = {src[1:0], pkt_seq[13:0], f[7:0], 8'($urandom)};
      fl.last  = (f == len - 1);
      fl.first = (f == 0);
      if (f == 0)             fl.gap = first_gap;
      else if (f == gap_flit) fl.gap = gap_len;
      else                    fl.gap = ($urandom_range(99) < mid_pct) ? $urandom_range(1, 2) : 0;
      flit_q[src].push_back(fl);
      if (to_exp) exp_q[src].push_back(fl);
    end
    pkt_seq++;
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (exp_q[k].size() != 0 || flit_q[k].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  task automatic step(input bit rdy);
    @(posedge clk);
    #1 router_rdy = rdy;
  endtask

  task automatic drain(input int rdy_pct, input int budget);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      step($urandom_range(99) < rdy_pct);
      n++;
    end
    check(n < budget, "drain_timeout", n, budget);
    step(1'b1);
    step(1'b1);
  endtask

  // Requester driver: one process owns all request inputs.
  initial begin
    bit presenting[NUM_REQ];
    bit accepted[NUM_REQ];
    bit gap_loaded[NUM_REQ];
    int gap_left[NUM_REQ];
    for (int k = 0; k < NUM_REQ; k++) begin
      presenting[k] = 1'b0;
      accepted[k]   = 1'b0;
      gap_loaded[k] = 1'b0;
      gap_left[k]   = 0;
      wait_active[k] = 1'b0;
      wait_start[k]  = 0;
    end
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!rst) begin
          flit_q[k].delete();
          presenting[k]  = 1'b0;
          accepted[k]    = 1'b0;
          gap_loaded[k]  = 1'b0;
          wait_active[k] = 1'b0;
        end else begin
          if (accepted[k]) begin
            flit_q[k].delete(0);
            presenting[k] = 1'b0;
            accepted[k]   = 1'b0;
          end
          if (!presenting[k] && flit_q[k].size() > 0) begin
            if (!gap_loaded[k]) begin
              gap_left[k]   = flit_q[k][0].gap;
              gap_loaded[k] = 1'b1;
            end
            if (gap_left[k] > 0) begin
              gap_left[k]--;
            end else begin
              presenting[k] = 1'b1;
              gap_loaded[k] = 1'b0;
              if (flit_q[k][0].first) begin
                wait_start[k]  = pkts_started;
                wait_active[k] = 1'b1;
              end
            end
          end
        end
        req_valid[k]          = presenting[k];
        req_last[k]           = presenting[k] ? flit_q[k][0].last : 1'($urandom);
        req_data[k*DW +: DW]  = presenting[k] ? flit_q[k][0].data : DW'($urandom);
      end
      @(negedge clk);
      for (int k = 0; k < NUM_REQ; k++) accepted[k] = req_valid[k] & req_rdy[k];
    end
  end

  // Output monitor: pops the scoreboard on every flit the router accepts.
  initial begin
    bit            held;
    logic [DW-1:0] held_data;
    bit            in_pkt;
    int            owner;
    int            src;
    int            g;
    flit_t         e;
    held = 1'b0;
    in_pkt = 1'b0;
    owner = 0;
    forever begin
      @(negedge clk);
      if (!rst || !mon_on) begin
        held   = 1'b0;
        in_pkt = 1'b0;
      end else begin
        if (held) check(tx_en === 1'b1 && tx_data === held_data, "stall_hold", tx_data, held_data);
        held      = (tx_en === 1'b1) && !router_rdy;
        held_data = tx_data;
        if (held) check(req_rdy === '0, "stall_req_rdy", req_rdy, 0);
        if (tx_en === 1'b1 && router_rdy) begin
          src = int'(tx_data[DW-1 -: 2]);
          if (src >= NUM_REQ || exp_q[src].size() == 0) begin
            check(1'b0, "unexpected_flit", tx_data, 0);
          end else begin
            e = exp_q[src].pop_front();
            check(tx_data === e.data, "flit_data", tx_data, e.data);
            if (in_pkt) begin
              check(src == owner, "no_interleave", src, owner);
            end else begin
              pkts_started++;
              if (exp_grant.size() > 0) begin
                g = exp_grant.pop_front();
                check(src == g, "grant_order", src, g);
              end
              if (wait_active[src]) begin
                check(pkts_started - wait_start[src] <= NUM_REQ + 2, "fairness",
                      pkts_started - wait_start[src], NUM_REQ + 2);
                wait_active[src] = 1'b0;
              end
            end
            in_pkt = !e.last;
            owner  = src;
          end
        end
      end
    end
  end

  initial begin
    rst        = 1'b0;
    router_rdy = 1'b1;

    // T1: reset values, async reset mid-packet, first grant after release.
    #2;
    check(tx_en === 1'b0, "rst_tx_en", tx_en, 0);
    check(req_rdy === '0, "rst_req_rdy", req_rdy, 0);
    check(grant_idx === '0, "rst_grant_idx", grant_idx, 0);
    check(busy === 1'b0, "rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    push_pkt(0, 4, 0, 0, 1'b0, -1, 0);
    repeat (3) @(posedge clk);
    #2 check(tx_en === 1'b1, "t1_pre_tx_en", tx_en, 1);
    #1 rst = 1'b0;
    #1;
    check(tx_en === 1'b0, "t1_mid_tx_en", tx_en, 0);
    check(req_rdy === '0, "t1_mid_req_rdy", req_rdy, 0);
    check(grant_idx === '0, "t1_mid_grant_idx", grant_idx, 0);
    check(busy === 1'b0, "t1_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    rst    = 1'b1;
    push_pkt(1, 1, 0, 0, 1'b1, -1, 0);
    exp_grant.push_back(1);
    @(posedge clk);
    @(posedge clk);
    #2 check(grant_idx === 2'd1, "t1_grant_after_rst", grant_idx, 1);
    drain(100, 200);

    // T2: all requesters with single-flit packets; pointer starts at 2 after T1's grant of 1.
    @(negedge clk);
    for (int p = 0; p < 4; p++)
      for (int s = 0; s < NUM_REQ; s++) push_pkt(s, 1, 0, 0, 1'b1, -1, 0);
    for (int p = 0; p < 12; p++) exp_grant.push_back((2 + p) % NUM_REQ);
    drain(100, 400);

    // T3: 4-flit packet from req0 must not be interleaved with req1.
    @(negedge clk);
    push_pkt(0, 4, 0, 0, 1'b1, -1, 0);
    push_pkt(1, 1, 0, 0, 1'b1, -1, 0);
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    drain(100, 200);

    // T4: router stalls 5 cycles mid-packet.
    @(negedge clk);
    push_pkt(2, 4, 0, 0, 1'b1, -1, 0);
    exp_grant.push_back(2);
    repeat (4) step(1'b1);
    repeat (5) step(1'b0);
    #1 check(tx_en === 1'b1 && busy === 1'b1, "t4_held_during_stall", {tx_en, busy}, 2'b11);
    drain(100, 200);

    // T5: granted req2 pauses 3 cycles mid-packet; req0/req1 arrive during the gap.
    @(negedge clk);
    push_pkt(2, 4, 0, 0, 1'b1, 2, 3);
    exp_grant.push_back(2);
    repeat (4) step(1'b1);
    push_pkt(0, 1, 0, 0, 1'b1, -1, 0);
    push_pkt(1, 1, 0, 0, 1'b1, -1, 0);
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    repeat (3) begin
      step(1'b1);
      #1;
      check(tx_en === 1'b0, "t5_gap_bubble", tx_en, 0);
      check(grant_idx === 2'd2, "t5_grant_locked", grant_idx, 2);
    end
    drain(100, 200);

    // T6: only req2 and req0; pointer wraps from 2 to 0.
    @(negedge clk);
    push_pkt(2, 2, 0, 0, 1'b1, -1, 0);
    push_pkt(2, 1, 0, 0, 1'b1, -1, 0);
    push_pkt(0, 1, 0, 0, 1'b1, -1, 0);
    push_pkt(0, 1, 0, 0, 1'b1, -1, 0);
    exp_grant.push_back(2);
    exp_grant.push_back(0);
    exp_grant.push_back(2);
    exp_grant.push_back(0);
    drain(100, 200);

    // Random stress, roughly 10k flits under random backpressure and gaps.
    @(negedge clk);
    for (int p = 0; p < 1340; p++)
      for (int s = 0; s < NUM_REQ; s++)
        push_pkt(s, $urandom_range(1, 4), ($urandom_range(3) == 0) ? $urandom_range(1, 6) : 0,
                 20, 1'b1, -1, 0);
    drain(85, 70000);

    check(exp_grant.size() == 0, "grant_queue_empty", exp_grant.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
